sha256_nonce_scheduler: RTL and testbench
=========================================

// Module: sha256_nonce_scheduler
// PURPOSE
// - Sequences one SHA-256 double-hash core across a nonce range for a single mining job.
// - Latches midstate/block2 template, inserts each nonce, starts the core, compares digest vs target.
// - Reports the first winning nonce or exhaustion. Sits between job intake and the sha256_wrapper core.
// PARAMETERS
// - NONCE_W        32    nonce width in bits
// - WDOG_CYCLES    1024  max cycles to wait for core_done before declaring core fault
// - WDOG_W         11    watchdog counter width, >= clog2(WDOG_CYCLES+1)
// PORTS
// - clk            in   1    clock
// - rst            in   1    reset, synchronous, active-high
// - job_valid      in   1    job offered; accepted when job_valid && job_ready
// - job_ready      out  1    high only in IDLE
// - job_midstate   in   256  midstate after first header block, [0:255] MSB-first
// - job_block2     in   512  padded second block template, [0:511] MSB-first
// - job_target     in   256  hash must be strictly less than this (unsigned)
// - job_nonce_lo   in   32   first nonce to try
// - job_nonce_hi   in   32   last nonce to try (inclusive)
// - abort          in   1    cancel running job, back to IDLE
// - core_midstate  out  256  registered copy of job_midstate
// - core_block2    out  512  template with current nonce inserted
// - core_start     out  1    one-cycle start pulse to core
// - core_done      in   1    one-cycle pulse, core_hash valid same cycle
// - core_hash      in   256  final double-SHA digest, MSB-first
// - found          out  1    one-cycle pulse: winning nonce on found_nonce
// - found_nonce    out  32   winning nonce, held until next job accepted
// - exhausted      out  1    one-cycle pulse: range finished with no winner
// - core_fault     out  1    sticky; watchdog expired; cleared by rst or next job accept
// BEHAVIOUR
// - Reset: state IDLE; job_ready=1; core_start, found, exhausted, core_fault=0; found_nonce=0;
//   core_midstate/core_block2=0.
// - Nonce insertion: core_block2 = template with bits [96:127] replaced by byte-reversed nonce
//   (bitcoin little-endian header field); all other bits untouched.
// - States: IDLE -> LOAD -> ISSUE -> WAIT -> CHECK -> {ISSUE | FOUND | DONE} -> IDLE.
// - IDLE: on accept latch all job fields, nonce_cur=job_nonce_lo, clear core_fault, go LOAD.
// - LOAD: register core_block2 for nonce_cur (1 cycle); go ISSUE.
// - ISSUE: assert core_start for exactly 1 cycle; clear watchdog; go WAIT.
// - WAIT: on core_done capture core_hash, go CHECK; watchdog increments each WAIT cycle;
//   at WDOG_CYCLES set core_fault, go IDLE (no found/exhausted pulse).
// - CHECK: hash < target -> found_nonce=nonce_cur, go FOUND; else if nonce_cur==nonce_hi go DONE;
//   else nonce_cur+=1, go LOAD.
// - FOUND: pulse found 1 cycle, go IDLE. DONE: pulse exhausted 1 cycle, go IDLE.
// - Latency per nonce: 3 cycles + core latency (LOAD, ISSUE, CHECK).
// - Range 0..32'hFFFFFFFF: compare is on equality to nonce_hi before increment; no wrap, no overflow.
// - lo > hi: only lo is tried, then exhausted.
// - core_done outside WAIT ignored. job_valid outside IDLE ignored (job_ready=0).
// - abort: highest priority in any non-IDLE state; next cycle IDLE, no pulses, core_start forced 0.
//   abort in IDLE with simultaneous job_valid: job accepted is suppressed (abort wins).
// - rst mid-job: all state to reset values next edge; in-flight core_done discarded.
// CONFIGURATION
// - SCHED_HASH_COUNT_EN defined: extra output hash_count [47:0], +1 on every CHECK,
//   cleared on rst only, saturates at all-ones. Undefined: port and counter absent.
// TESTING
// - Job lo=5 hi=7, target=all-ones, core_done 4 cycles after start, hash=0 -> found pulse, found_nonce=5, one core_start.
// - lo=5 hi=7, target=0 -> three core_start pulses (nonces 5,6,7), exhausted pulse once, found never.
// - Nonce insertion: template all-zero, nonce 32'h11223344 -> core_block2[96:127]=32'h44332211, rest zero.
// - Hash equal to target -> not a win; hash = target-1 -> found.
// - Core never answers: core_fault=1 after 1024 WAIT cycles, state IDLE, job_ready=1.
// - abort 2 cycles after core_start with core_done same cycle -> no found/exhausted, job_ready=1 next cycle.

Source files
------------

// File: rtl/sha256_nonce_scheduler.sv
// rtl/sha256_nonce_scheduler.sv - walks one mining job's nonce range through a double-SHA core.
// Optional SCHED_HASH_COUNT_EN adds a saturating 48-bit hash_count output.
module sha256_nonce_scheduler #(
  parameter int NONCE_W     = 32,
  parameter int WDOG_CYCLES = 1024,
  parameter int WDOG_W      = 11
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               job_valid,
  output logic               job_ready,
  input  logic [0:255]       job_midstate,
  input  logic [0:511]       job_block2,
  input  logic [0:255]       job_target,
  input  logic [NONCE_W-1:0] job_nonce_lo,
  input  logic [NONCE_W-1:0] job_nonce_hi,
  input  logic               abort,
  output logic [0:255]       core_midstate,
  output logic [0:511]       core_block2,
  output logic               core_start,
  input  logic               core_done,
  input  logic [0:255]       core_hash,
  output logic               found,
  output logic [NONCE_W-1:0] found_nonce,
  output logic               exhausted,
`ifdef SCHED_HASH_COUNT_EN
  output logic [47:0]        hash_count,
`endif
  output logic               core_fault
);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_ISSUE, S_WAIT, S_CHECK, S_FOUND, S_DONE
  } state_t;

  state_t               state_q, state_d;
  logic [0:255]         midstate_q, midstate_d;
  logic [0:511]         template_q, template_d;
  logic [0:511]         block2_q, block2_d;
  logic [0:255]         target_q, target_d;
  logic [0:255]         hash_q, hash_d;
  logic [NONCE_W-1:0]   nonce_cur_q, nonce_cur_d;
  logic [NONCE_W-1:0]   nonce_hi_q, nonce_hi_d;
  logic [NONCE_W-1:0]   found_nonce_q, found_nonce_d;
  logic [WDOG_W-1:0]    wdog_q, wdog_d;
  logic                 core_fault_q, core_fault_d;
  logic [NONCE_W-1:0]   nonce_le;
`ifdef SCHED_HASH_COUNT_EN
  logic [47:0]          hash_count_q, hash_count_d;
`endif

  always_comb begin
    state_d       = state_q;
    midstate_d    = midstate_q;
    template_d    = template_q;
    block2_d      = block2_q;
    target_d      = target_q;
    hash_d        = hash_q;
    nonce_cur_d   = nonce_cur_q;
    nonce_hi_d    = nonce_hi_q;
    found_nonce_d = found_nonce_q;
    wdog_d        = wdog_q;
    core_fault_d  = core_fault_q;
`ifdef SCHED_HASH_COUNT_EN
    hash_count_d  = hash_count_q;
`endif
    core_start    = 1'b0;
    found         = 1'b0;
    exhausted     = 1'b0;
    // Header nonce field is little-endian, so the bytes go in reversed.
    nonce_le      = {<<8{nonce_cur_q}};

    case (state_q)
      S_IDLE: begin
        if (job_valid && !abort) begin
          midstate_d    = job_midstate;
          template_d    = job_block2;
          target_d      = job_target;
          nonce_cur_d   = job_nonce_lo;
          nonce_hi_d    = job_nonce_hi;
          found_nonce_d = '0;
          core_fault_d  = 1'b0;
          state_d       = S_LOAD;
        end
      end
      S_LOAD: begin
        block2_d                = template_q;
        block2_d[96 +: NONCE_W] = nonce_le;
        state_d                 = S_ISSUE;
      end
      S_ISSUE: begin
        core_start = 1'b1;
        wdog_d     = '0;
        state_d    = S_WAIT;
      end
      S_WAIT: begin
        if (core_done) begin
          hash_d  = core_hash;
          state_d = S_CHECK;
        end else if (wdog_q == WDOG_W'(WDOG_CYCLES - 1)) begin
          core_fault_d = 1'b1;
          state_d      = S_IDLE;
        end else begin
          wdog_d = wdog_q + WDOG_W'(1);
        end
      end
      S_CHECK: begin
`ifdef SCHED_HASH_COUNT_EN
        if (hash_count_q != '1) hash_count_d = hash_count_q + 48'd1;
`endif
        // >= rather than == also ends a lo > hi job after the single lo attempt.
        if (hash_q < target_q) begin
          found_nonce_d = nonce_cur_q;
          state_d       = S_FOUND;
        end else if (nonce_cur_q >= nonce_hi_q) begin
          state_d = S_DONE;
        end else begin
          nonce_cur_d = nonce_cur_q + NONCE_W'(1);
          state_d     = S_LOAD;
        end
      end
      S_FOUND: begin
        found   = 1'b1;
        state_d = S_IDLE;
      end
      S_DONE: begin
        exhausted = 1'b1;
        state_d   = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (abort && state_q != S_IDLE) begin
      state_d       = S_IDLE;
      core_start    = 1'b0;
      found         = 1'b0;
      exhausted     = 1'b0;
      found_nonce_d = found_nonce_q;
      core_fault_d  = core_fault_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      midstate_q    <= '0;
      template_q    <= '0;
      block2_q      <= '0;
      target_q      <= '0;
      hash_q        <= '0;
      nonce_cur_q   <= '0;
      nonce_hi_q    <= '0;
      found_nonce_q <= '0;
      wdog_q        <= '0;
      core_fault_q  <= 1'b0;
`ifdef SCHED_HASH_COUNT_EN
      hash_count_q  <= '0;
`endif
    end else begin
      state_q       <= state_d;
      midstate_q    <= midstate_d;
      template_q    <= template_d;
      block2_q      <= block2_d;
      target_q      <= target_d;
      hash_q        <= hash_d;
      nonce_cur_q   <= nonce_cur_d;
      nonce_hi_q    <= nonce_hi_d;
      found_nonce_q <= found_nonce_d;
      wdog_q        <= wdog_d;
      core_fault_q  <= core_fault_d;
`ifdef SCHED_HASH_COUNT_EN
      hash_count_q  <= hash_count_d;
`endif
    end
  end

  assign job_ready     = (state_q == S_IDLE);
  assign core_midstate = midstate_q;
  assign core_block2   = block2_q;
  assign found_nonce   = found_nonce_q;
  assign core_fault    = core_fault_q;
`ifdef SCHED_HASH_COUNT_EN
  assign hash_count    = hash_count_q;
`endif

endmodule

// File: tb/tb_sha256_nonce_scheduler.sv
// tb/tb_sha256_nonce_scheduler.sv - randomized and directed checks of sha256_nonce_scheduler against a timeline model.
module tb_sha256_nonce_scheduler;
  localparam int WDOG = 1024;

  logic         clk = 1'b0;
  logic         rst;
  logic         job_valid, job_ready, abort, core_start, core_done;
  logic [0:255] job_midstate, job_target, core_midstate, core_hash;
  logic [0:511] job_block2, core_block2;
  logic [31:0]  job_nonce_lo, job_nonce_hi, found_nonce;
  logic         found, exhausted, core_fault;
`ifdef SCHED_HASH_COUNT_EN
  logic [47:0]  hash_count;
`endif

  sha256_nonce_scheduler dut (
    .clk(clk), .rst(rst), .job_valid(job_valid), .job_ready(job_ready),
    .job_midstate(job_midstate), .job_block2(job_block2), .job_target(job_target),
    .job_nonce_lo(job_nonce_lo), .job_nonce_hi(job_nonce_hi), .abort(abort),
    .core_midstate(core_midstate), .core_block2(core_block2), .core_start(core_start),
    .core_done(core_done), .core_hash(core_hash), .found(found), .found_nonce(found_nonce),
    .exhausted(exhausted),
`ifdef SCHED_HASH_COUNT_EN
    .hash_count(hash_count),
`endif
    .core_fault(core_fault)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [0:255] hash_tab [0:15];
  logic [0:511] last_blk;
  int           last_starts;

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [0:255] rnd256();
    logic [0:255] r;
    for (int i = 0; i < 8; i++) r[32*i +: 32] = $urandom;
    return r;
  endfunction

  function automatic logic [0:511] rnd512();
    logic [0:511] r;
    for (int i = 0; i < 16; i++) r[32*i +: 32] = $urandom;
    return r;
  endfunction

  // Header bytes 12..15 of block 2 carry the nonce, least significant byte first.
  function automatic logic [0:511] put_nonce(input logic [0:511] t, input logic [31:0] n);
    logic [0:511] r;
    r = t;
    for (int b = 0; b < 4; b++) r[96 + 8*b +: 8] = n[8*b +: 8];
    return r;
  endfunction

  // Interval 1 is the cycle after the accepting edge. Each nonce costs LOAD, ISSUE,
  // lat WAIT cycles and CHECK, so nonce k starts in interval 2 + k*(3+lat).
  task automatic run_job(input logic [31:0] lo, input logic [31:0] hi, input logic [0:255] tgt,
                         input logic [0:511] tmpl, input logic [0:255] mid, input int lat,
                         input int abort_at, input bit no_answer);
    int n, ntry, per, end_iv, idle_iv, starts, done_iv, sidx;
    bit won, e_start;
    logic [31:0] win_nonce;
    n = (lo > hi) ? 1 : int'(hi - lo) + 1;
    ntry = n;
    won = 1'b0;
    if (!no_answer) begin
      for (int i = 0; i < n; i++)
        if (hash_tab[i] < tgt) begin won = 1'b1; ntry = i + 1; break; end
    end else ntry = 1;
    per = 3 + lat;
    win_nonce = lo + 32'(ntry - 1);
    if (no_answer) begin end_iv = -1; idle_iv = 3 + WDOG; end
    else begin end_iv = 1 + ntry * per; idle_iv = end_iv + 1; end
    if (abort_at >= 0) begin end_iv = -1; idle_iv = abort_at + 1; won = 1'b0; end

    @(negedge clk);
    job_valid = 1'b1; job_nonce_lo = lo; job_nonce_hi = hi; job_target = tgt;
    job_block2 = tmpl; job_midstate = mid; abort = 1'b0; core_done = 1'b0;
    @(posedge clk);
    starts = 0; done_iv = -1; sidx = 0;
    for (int iv = 1; iv <= idle_iv; iv++) begin
      @(negedge clk);
      job_valid    = (iv < idle_iv) ? 1'($urandom) : 1'b0;
      job_nonce_lo = $urandom; job_nonce_hi = $urandom;
      job_target   = rnd256(); job_midstate = rnd256(); job_block2 = rnd512();
      abort        = (iv == abort_at);
      if (iv == done_iv) begin
        core_done = 1'b1; core_hash = hash_tab[sidx];
      end else begin
        core_done = !no_answer && (iv % per == 1) && (iv < idle_iv) && 1'($urandom);
        core_hash = '0;
      end
      #1;
      e_start = (iv >= 2) && ((iv - 2) % per == 0) && ((iv - 2) / per < ntry) &&
                (iv < idle_iv) && (abort_at < 0 || iv < abort_at);
      chk("core_start", core_start, e_start);
      chk("found", found, won && iv == end_iv);
      chk("exhausted", exhausted, !won && end_iv > 0 && iv == end_iv);
      chk("job_ready", job_ready, iv == idle_iv);
      chk("core_fault", core_fault, no_answer && iv >= idle_iv);
      chk("found_nonce", found_nonce, (won && iv >= end_iv) ? win_nonce : 32'h0);
      if (core_start) begin
        chk("core_block2", core_block2, put_nonce(tmpl, lo + 32'(starts)));
        chk("core_midstate", core_midstate, mid);
        last_blk = core_block2;
        if (!no_answer && starts < 16) begin done_iv = iv + lat; sidx = starts; end
        starts++;
      end
    end
    core_done = 1'b0;
    abort = 1'b0;
    last_starts = starts;
  endtask

  initial begin : main
    logic [0:255] tgt;
    logic [0:511] exp_blk;
    logic [31:0]  lo, hi, tmp;
    int           lat, size, ab;

    rst = 1'b1; job_valid = 1'b0; abort = 1'b0; core_done = 1'b0; core_hash = '0;
    job_midstate = '0; job_block2 = '0; job_target = '0; job_nonce_lo = '0; job_nonce_hi = '0;
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    chk("rst_job_ready", job_ready, 1'b1);
    chk("rst_core_start", core_start, 1'b0);
    chk("rst_found", found, 1'b0);
    chk("rst_exhausted", exhausted, 1'b0);
    chk("rst_core_fault", core_fault, 1'b0);
    chk("rst_found_nonce", found_nonce, 32'h0);
    chk("rst_core_midstate", core_midstate, 256'h0);
    chk("rst_core_block2", core_block2, 512'h0);
    rst = 1'b0;

    // First nonce wins with a maximal target.
    for (int i = 0; i < 16; i++) hash_tab[i] = '0;
    run_job(32'd5, 32'd7, '1, rnd512(), rnd256(), 4, -1, 1'b0);
    chk("t1_starts", last_starts, 1);
    chk("t1_found_nonce", found_nonce, 32'd5);

    // Zero target can never win: all three nonces tried.
    run_job(32'd5, 32'd7, '0, rnd512(), rnd256(), 3, -1, 1'b0);
    chk("t2_starts", last_starts, 3);
    chk("t2_found_nonce", found_nonce, 32'd0);

    // Byte-reversed nonce insertion into an all-zero template.
    run_job(32'h11223344, 32'h11223344, '0, '0, rnd256(), 2, -1, 1'b0);
    exp_blk = '0;
    exp_blk[96:127] = 32'h44332211;
    chk("t3_insert", last_blk, exp_blk);

    // Equal hash is not a win, target-1 is.
    tgt = rnd256() | 256'h1;
    hash_tab[0] = tgt;
    hash_tab[1] = tgt - 256'd1;
    run_job(32'd10, 32'd11, tgt, rnd512(), rnd256(), 1, -1, 1'b0);
    chk("t4_starts", last_starts, 2);
    chk("t4_found_nonce", found_nonce, 32'd11);

    // Silent core trips the watchdog.
    run_job(32'd1, 32'd3, '1, rnd512(), rnd256(), 5, -1, 1'b1);
    chk("t5_fault", core_fault, 1'b1);
    chk("t5_starts", last_starts, 1);

    // Answer on the last permitted WAIT cycle still counts; fault clears on accept.
    hash_tab[0] = '0;
    run_job(32'd9, 32'd9, '1, rnd512(), rnd256(), WDOG, -1, 1'b0);
    chk("t5b_fault", core_fault, 1'b0);
    chk("t5b_found_nonce", found_nonce, 32'd9);

    // Abort two cycles after the start, coinciding with core_done.
    run_job(32'd5, 32'd7, '1, rnd512(), rnd256(), 2, 4, 1'b0);
    chk("t6_starts", last_starts, 1);

    // Top of the nonce space: no wrap past all-ones.
    run_job(32'hFFFFFFFE, 32'hFFFFFFFF, '0, rnd512(), rnd256(), 2, -1, 1'b0);
    chk("t7_starts", last_starts, 2);

    // lo > hi tries only lo.
    run_job(32'd20, 32'd3, '0, rnd512(), rnd256(), 1, -1, 1'b0);
    chk("t8_starts", last_starts, 1);

    // Abort in IDLE suppresses a simultaneous job offer.
    @(negedge clk); job_valid = 1'b1; abort = 1'b1;
    @(negedge clk); job_valid = 1'b0; abort = 1'b0; #1;
    chk("t9_idle_ready", job_ready, 1'b1);
    @(negedge clk); #1;
    chk("t9_no_start", core_start, 1'b0);

    // Reset mid-job discards an in-flight answer.
    @(negedge clk);
    job_valid = 1'b1; job_nonce_lo = 32'd1; job_nonce_hi = 32'd1; job_target = '1;
    job_midstate = rnd256(); job_block2 = rnd512();
    @(negedge clk); job_valid = 1'b0;
    @(negedge clk);
    @(negedge clk); rst = 1'b1; core_done = 1'b1; core_hash = '0;
    @(negedge clk); rst = 1'b0; core_done = 1'b0; #1;
    chk("t10_ready", job_ready, 1'b1);
    chk("t10_block2", core_block2, 512'h0);
    chk("t10_midstate", core_midstate, 256'h0);
    chk("t10_found_nonce", found_nonce, 32'h0);
    repeat (4) begin
      @(negedge clk); #1;
      chk("t10_no_found", found, 1'b0);
      chk("t10_no_start", core_start, 1'b0);
    end

    // Randomized jobs.
    for (int j = 0; j < 40; j++) begin
      lat  = 1 + int'($urandom % 6);
      size = 1 + int'($urandom % 4);
      if ($urandom % 4 == 0) begin
        hi = 32'hFFFFFFFF; lo = hi - 32'(size - 1);
      end else begin
        lo = $urandom; hi = lo + 32'(size - 1);
        if (hi < lo) hi = 32'hFFFFFFFF;
      end
      if ($urandom % 8 == 0 && lo != hi) begin tmp = lo; lo = hi; hi = tmp; end
      tgt = rnd256();
      for (int i = 0; i < 16; i++) begin
        case ($urandom % 4)
          0: hash_tab[i] = tgt;
          1: hash_tab[i] = tgt | rnd256();
          2: hash_tab[i] = (tgt != 0) ? tgt - 256'd1 : tgt;
          default: hash_tab[i] = (tgt != 0) ? rnd256() % tgt : tgt;
        endcase
      end
      ab = ($urandom % 6 == 0) ? 3 + int'($urandom % lat) : -1;
      run_job(lo, hi, tgt, rnd512(), rnd256(), lat, ab, 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
